// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse keyer: the ROM code word,
// the keyer state encoding, element/gap lengths in units, and ASCII case folding.
package morse_pkg;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } morse_code_t;

    localparam int unsigned DOT_UNITS  = 1;
    localparam int unsigned DASH_UNITS = 3;
    localparam int unsigned EGAP_UNITS = 1;
    localparam int unsigned CGAP_UNITS = 3;
    localparam int unsigned WGAP_UNITS = 4;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        EGAP,
        CGAP,
        WORD_GAP
    } morse_state_t;

    function automatic logic [7:0] fold_case(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ASCII to Morse lookup; pat is left-aligned, MSB is element 0, 1 = dash.
// Digits are present only when MORSE_KEYER_DIGITS_EN is defined; len 0 marks unsupported.
module morse_rom
    import morse_pkg::*;
(
    input  logic [7:0]  char_data,
    output morse_code_t code
);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        code = '{len: 3'd0, pat: 5'b00000};
        case (fold_case(char_data))
            8'h41: code = '{len: 3'd2, pat: 5'b01000};
            8'h42: code = '{len: 3'd4, pat: 5'b10000};
            8'h43: code = '{len: 3'd4, pat: 5'b10100};
            8'h44: code = '{len: 3'd3, pat: 5'b10000};
            8'h45: code = '{len: 3'd1, pat: 5'b00000};
            8'h46: code = '{len: 3'd4, pat: 5'b00100};
            8'h47: code = '{len: 3'd3, pat: 5'b11000};
            8'h48: code = '{len: 3'd4, pat: 5'b00000};
            8'h49: code = '{len: 3'd2, pat: 5'b00000};
            8'h4A: code = '{len: 3'd4, pat: 5'b01110};
            8'h4B: code = '{len: 3'd3, pat: 5'b10100};
            8'h4C: code = '{len: 3'd4, pat: 5'b01000};
            8'h4D: code = '{len: 3'd2, pat: 5'b11000};
            8'h4E: code = '{len: 3'd2, pat: 5'b10000};
            8'h4F: code = '{len: 3'd3, pat: 5'b11100};
            8'h50: code = '{len: 3'd4, pat: 5'b01100};
            8'h51: code = '{len: 3'd4, pat: 5'b11010};
            8'h52: code = '{len: 3'd3, pat: 5'b01000};
            8'h53: code = '{len: 3'd3, pat: 5'b00000};
            8'h54: code = '{len: 3'd1, pat: 5'b10000};
            8'h55: code = '{len: 3'd3, pat: 5'b00100};
            8'h56: code = '{len: 3'd4, pat: 5'b00010};
            8'h57: code = '{len: 3'd3, pat: 5'b01100};
            8'h58: code = '{len: 3'd4, pat: 5'b10010};
            8'h59: code = '{len: 3'd4, pat: 5'b10110};
            8'h5A: code = '{len: 3'd4, pat: 5'b11000};
`ifdef MORSE_KEYER_DIGITS_EN
            8'h30: code = '{len: 3'd5, pat: 5'b11111};
            8'h31: code = '{len: 3'd5, pat: 5'b01111};
            8'h32: code = '{len: 3'd5, pat: 5'b00111};
            8'h33: code = '{len: 3'd5, pat: 5'b00011};
            8'h34: code = '{len: 3'd5, pat: 5'b00001};
            8'h35: code = '{len: 3'd5, pat: 5'b00000};
            8'h36: code = '{len: 3'd5, pat: 5'b10000};
            8'h37: code = '{len: 3'd5, pat: 5'b11000};
            8'h38: code = '{len: 3'd5, pat: 5'b11100};
            8'h39: code = '{len: 3'd5, pat: 5'b11110};
`endif
            default: code = '{len: 3'd0, pat: 5'b00000};
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// ASCII-in, Morse-out keyer: valid/ready character intake, element/gap FSM and unit timing.
// Define MORSE_KEYER_DIGITS_EN to key digits 0-9; otherwise they pulse err like any unsupported code.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 2097152
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key,
    output logic       busy,
    output logic       err
);

    localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

    morse_state_t state, next_state;
    morse_state_t start_state;
    morse_code_t  rom_code, code_q;
    logic [2:0]   elem_idx;
    logic [CNT_W-1:0] unit_cnt;
    logic [2:0]   unit_num;
    logic [2:0]   phase_units;
    logic         tick, phase_done, gap_end, accept, is_space, cur_dash;
    logic         key_next, err_next;

    morse_rom u_rom (
        .char_data (char_data),
        .code      (rom_code)
    );

    // Decode of the offered character and current phase timing.
    always_comb begin
        is_space    = (char_data == ASCII_SPACE);
        start_state = IDLE;
        if (is_space)
            start_state = WORD_GAP;
        else if (rom_code.len != 3'd0)
            start_state = MARK;

        cur_dash    = code_q.pat[3'd4 - elem_idx];
        phase_units = 3'(EGAP_UNITS);
        case (state)
            MARK:     phase_units = cur_dash ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
            EGAP:     phase_units = 3'(EGAP_UNITS);
            CGAP:     phase_units = 3'(CGAP_UNITS);
            WORD_GAP: phase_units = 3'(WGAP_UNITS);
            default:  phase_units = 3'(EGAP_UNITS);
        endcase

        tick       = (unit_cnt == UNIT_LAST);
        phase_done = tick && (unit_num == phase_units - 3'd1) && (state != IDLE);
        gap_end    = phase_done && (state == CGAP || state == WORD_GAP);
        accept     = char_valid && char_ready;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            // NOTE: non-blocking for every flop so all registers update from pre-edge values.
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept) next_state = start_state;
            MARK:     if (phase_done)
                          next_state = (elem_idx + 3'd1 < code_q.len) ? EGAP : CGAP;
            EGAP:     if (phase_done) next_state = MARK;
            CGAP,
            WORD_GAP: if (phase_done) next_state = accept ? start_state : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Ready also covers the last gap cycle so a waiting character follows with no idle cycle.
    always_comb begin
        char_ready = (state == IDLE) || gap_end;
        busy       = (state != IDLE);
        key_next   = (next_state == MARK);
        err_next   = accept && !is_space && (rom_code.len == 3'd0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key <= 1'b0;
            err <= 1'b0;
        end else begin
            key <= key_next;
            err <= err_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            code_q   <= '{len: 3'd0, pat: 5'b00000};
            elem_idx <= 3'd0;
        end else if (accept && start_state == MARK) begin
            code_q   <= rom_code;
            elem_idx <= 3'd0;
        end else if (state == MARK && phase_done) begin
            elem_idx <= elem_idx + 3'd1;
        end
    end

    // Both counters restart at every phase boundary so each phase is a whole number of units.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            unit_cnt <= '0;
            unit_num <= 3'd0;
        end else begin
            if (state == IDLE || tick)
                unit_cnt <= '0;
            else
                unit_cnt <= unit_cnt + 1'b1;

            if (state == IDLE || phase_done)
                unit_num <= 3'd0;
            else if (tick)
                unit_num <= unit_num + 3'd1;
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer at UNIT_CYCLES = 4; expected key waveforms are built from
// hand-written mark/space run lengths.
module tb_morse_keyer;

    localparam int unsigned U = 4;
    localparam int MAXC = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready, key, busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_q[$];
    int         acc_q[$];
    int         runs[$];
    logic       kt[MAXC];
    logic       bt[MAXC];
    logic       rt[MAXC];
    logic       et[MAXC];
    logic       exp_key[MAXC];

    morse_keyer #(.UNIT_CYCLES(U)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key        (key),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Feeds tx_q over the handshake for n cycles; index k holds outputs after posedge k.
    task automatic run_stream(input int n);
        logic r;
        acc_q.delete();
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            char_valid = (tx_q.size() > 0);
            char_data  = char_valid ? tx_q[0] : 8'h00;
            r = char_ready;
            @(posedge clk);
            if (char_valid && r) begin
                void'(tx_q.pop_front());
                acc_q.push_back(k);
            end
            @(negedge clk);
            kt[k] = key;
            bt[k] = busy;
            rt[k] = char_ready;
            et[k] = err;
        end
        char_valid = 1'b0;
    endtask

    // Expands runs (alternating high/low, starting high) into exp_key.
    task automatic build_exp();
        int   idx;
        logic lvl;
        idx = 0;
        lvl = 1'b1;
        for (int i = 0; i < MAXC; i++) exp_key[i] = 1'b0;
        foreach (runs[r]) begin
            for (int j = 0; j < runs[r]; j++) begin
                exp_key[idx] = lvl;
                idx++;
            end
            lvl = !lvl;
        end
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (key !== 1'b0) begin n_fail++; $display("FAIL reset_key: got %b want 0", key); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_tests++;
        if (char_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", char_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_e();
        int bad;
        tx_q = {8'h45};
        run_stream(24);
        runs = {4, 12};
        build_exp();
        n_tests++;
        if (acc_q.size() !== 1 || acc_q[0] !== 0) begin
            n_fail++; $display("FAIL e_accept: got %0d accepts want 1 at cycle 0", acc_q.size());
        end
        bad = -1;
        for (int k = 0; k < 24; k++) if (kt[k] !== exp_key[k] && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL e_key: cycle %0d got %b want %b", bad, kt[bad], exp_key[bad]); end
        bad = -1;
        for (int k = 0; k < 24; k++) if (bt[k] !== (k < 16) && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL e_busy: cycle %0d got %b want %b", bad, bt[bad], (bad < 16)); end
        bad = -1;
        for (int k = 0; k < 15; k++) if (rt[k] !== 1'b0 && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL e_ready_low: cycle %0d got %b want 0", bad, rt[bad]); end
        n_tests++;
        if (rt[16] !== 1'b1) begin n_fail++; $display("FAIL e_ready_back: got %b want 1", rt[16]); end
    endtask

    task automatic test_back_to_back();
        int bad;
        tx_q = {8'h53, 8'h4F, 8'h53};
        run_stream(130);
        runs = {4, 4, 4, 4, 4, 12, 12, 4, 12, 4, 12, 12, 4, 4, 4, 4, 4, 12};
        build_exp();
        n_tests++;
        if (acc_q.size() !== 3) begin
            n_fail++; $display("FAIL sos_accept_count: got %0d want 3", acc_q.size());
        end else if (acc_q[0] !== 0 || acc_q[1] !== 32 || acc_q[2] !== 88) begin
            n_fail++; $display("FAIL sos_accept_cycles: got %0d %0d %0d want 0 32 88", acc_q[0], acc_q[1], acc_q[2]);
        end
        bad = -1;
        for (int k = 0; k < 130; k++) if (kt[k] !== exp_key[k] && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL sos_key: cycle %0d got %b want %b", bad, kt[bad], exp_key[bad]); end
        bad = -1;
        for (int k = 0; k < 130; k++) if (bt[k] !== (k < 120) && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL sos_busy: cycle %0d got %b want %b", bad, bt[bad], (bad < 120)); end
    endtask

    task automatic test_case_fold();
        int bad;
        runs = {4, 4, 12, 12};
        build_exp();
        tx_q = {8'h61};
        run_stream(40);
        bad = -1;
        for (int k = 0; k < 40; k++) if (kt[k] !== exp_key[k] && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL lower_a_key: cycle %0d got %b want %b", bad, kt[bad], exp_key[bad]); end
        n_tests++;
        if (bt[31] !== 1'b1 || bt[32] !== 1'b0) begin
            n_fail++; $display("FAIL lower_a_busy_end: got %b%b want 10", bt[31], bt[32]);
        end
        tx_q = {8'h41};
        run_stream(40);
        bad = -1;
        for (int k = 0; k < 40; k++) if (kt[k] !== exp_key[k] && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL upper_a_key: cycle %0d got %b want %b", bad, kt[bad], exp_key[bad]); end
    endtask

    task automatic test_space();
        int bad;
        tx_q = {8'h20};
        run_stream(24);
        bad = -1;
        for (int k = 0; k < 24; k++) if (kt[k] !== 1'b0 && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL space_key: cycle %0d got %b want 0", bad, kt[bad]); end
        bad = -1;
        for (int k = 0; k < 24; k++) if (bt[k] !== (k < 16) && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL space_busy: cycle %0d got %b want %b", bad, bt[bad], (bad < 16)); end
    endtask

    task automatic test_unsupported(input logic [7:0] c, input string tag);
        int bad;
        tx_q = {c};
        run_stream(8);
        n_tests++;
        if (acc_q.size() !== 1 || acc_q[0] !== 0) begin
            n_fail++; $display("FAIL %s_accept: got %0d accepts want 1 at cycle 0", tag, acc_q.size());
        end
        bad = -1;
        for (int k = 0; k < 8; k++) if (et[k] !== (k == 0) && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL %s_err: cycle %0d got %b want %b", tag, bad, et[bad], (bad == 0)); end
        bad = -1;
        for (int k = 0; k < 8; k++) if ((rt[k] !== 1'b1 || bt[k] !== 1'b0 || kt[k] !== 1'b0) && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL %s_quiet: cycle %0d ready=%b busy=%b key=%b want 1 0 0", tag, bad, rt[bad], bt[bad], kt[bad]);
        end
    endtask

    task automatic test_digit();
`ifdef MORSE_KEYER_DIGITS_EN
        int bad;
        tx_q = {8'h35};
        run_stream(60);
        runs = {4, 4, 4, 4, 4, 4, 4, 4, 4, 12};
        build_exp();
        bad = -1;
        for (int k = 0; k < 60; k++) if (kt[k] !== exp_key[k] && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL digit5_key: cycle %0d got %b want %b", bad, kt[bad], exp_key[bad]); end
        n_tests++;
        if (et[0] !== 1'b0) begin n_fail++; $display("FAIL digit5_err: got %b want 0", et[0]); end
`else
        test_unsupported(8'h35, "digit5");
`endif
    endtask

    task automatic test_reset_mid();
        int bad;
        tx_q = {8'h54};
        run_stream(6);
        n_tests++;
        if (kt[5] !== 1'b1) begin n_fail++; $display("FAIL t_mark_before_reset: got %b want 1", kt[5]); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (key !== 1'b0) begin n_fail++; $display("FAIL reset_mid_key: got %b want 0", key); end
        n_tests++;
        if (busy !== 1'b0 || char_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_state: busy=%b ready=%b want 0 1", busy, char_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tx_q = {8'h45};
        run_stream(24);
        runs = {4, 12};
        build_exp();
        n_tests++;
        if (acc_q.size() !== 1 || acc_q[0] !== 0) begin
            n_fail++; $display("FAIL post_reset_accept: got %0d accepts want 1 at cycle 0", acc_q.size());
        end
        bad = -1;
        for (int k = 0; k < 24; k++) if (kt[k] !== exp_key[k] && bad < 0) bad = k;
        n_tests++;
        if (bad >= 0) begin n_fail++; $display("FAIL post_reset_key: cycle %0d got %b want %b", bad, kt[bad], exp_key[bad]); end
    endtask

    initial begin
        test_reset();
        test_e();
        test_back_to_back();
        test_case_fold();
        test_space();
        test_unsupported(8'h23, "hash");
        test_digit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
